// File: rtl/dot_product_reduce_if.sv
// Paired partial-sum inputs and the frame-total output stream of dot_product_reduce.
// Each word moves on a rising clock edge where its vld and ack are both high.
interface dot_product_reduce_if;
  logic [31:0] Input_1_V_V;
  logic        Input_1_V_V_ap_vld;
  logic        Input_1_V_V_ap_ack;
  logic [31:0] Input_2_V_V;
  logic        Input_2_V_V_ap_vld;
  logic        Input_2_V_V_ap_ack;
  logic [31:0] Output_1_V_V;
  logic        Output_1_V_V_ap_vld;
  logic        Output_1_V_V_ap_ack;

  modport master (
    output Input_1_V_V, Input_1_V_V_ap_vld, Input_2_V_V, Input_2_V_V_ap_vld,
    output Output_1_V_V_ap_ack,
    input  Input_1_V_V_ap_ack, Input_2_V_V_ap_ack, Output_1_V_V, Output_1_V_V_ap_vld
  );

  modport slave (
    input  Input_1_V_V, Input_1_V_V_ap_vld, Input_2_V_V, Input_2_V_V_ap_vld,
    input  Output_1_V_V_ap_ack,
    output Input_1_V_V_ap_ack, Input_2_V_V_ap_ack, Output_1_V_V, Output_1_V_V_ap_vld
  );
endinterface

// File: rtl/dot_product_reduce.sv
// Adds paired partial sums, accumulates NUM_TERMS pairs per frame and emits one total per frame.
// A one-deep result slot lets the next frame accumulate while the previous total waits on backpressure.
module dot_product_reduce #(
  parameter int NUM_TERMS = 8,
  parameter int CNT_BITS  = 8
) (
  input  logic                 ap_clk,
  input  logic                 ap_rst_n,
  dot_product_reduce_if.slave  s,
  output logic [15:0]          frames_done
);

  localparam logic [CNT_BITS-1:0] LAST = CNT_BITS'(NUM_TERMS - 1);

  logic [31:0]         acc_q, acc_d;
  logic [CNT_BITS-1:0] cnt_q, cnt_d;
  logic [31:0]         out_data_q, out_data_d;
  logic                out_vld_q, out_vld_d;
  logic [15:0]         frames_q, frames_d;

  logic        pair_ok, is_last, slot_free, take;
  logic [31:0] sum;

  assign pair_ok   = s.Input_1_V_V_ap_vld & s.Input_2_V_V_ap_vld;
  assign is_last   = (cnt_q == LAST);
  // Only the closing term needs the result slot; earlier terms flow even under backpressure.
  assign slot_free = ~out_vld_q | s.Output_1_V_V_ap_ack;
  assign take      = pair_ok & (~is_last | slot_free);
  assign sum       = acc_q + s.Input_1_V_V + s.Input_2_V_V;

  assign s.Input_1_V_V_ap_ack  = take;
  assign s.Input_2_V_V_ap_ack  = take;
  assign s.Output_1_V_V        = out_data_q;
  assign s.Output_1_V_V_ap_vld = out_vld_q;
  assign frames_done           = frames_q;

  always_comb begin
    acc_d      = acc_q;
    cnt_d      = cnt_q;
    out_data_d = out_data_q;
    out_vld_d  = out_vld_q;
    frames_d   = frames_q;
    if (out_vld_q && s.Output_1_V_V_ap_ack) begin
      out_vld_d = 1'b0;
      frames_d  = frames_q + 16'd1;
    end
    // A last-term accept in the same cycle as a drain refills the slot with no bubble.
    if (take) begin
      if (is_last) begin
        out_data_d = sum;
        out_vld_d  = 1'b1;
        acc_d      = '0;
        cnt_d      = '0;
      end else begin
        acc_d = sum;
        cnt_d = cnt_q + CNT_BITS'(1);
      end
    end
  end

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      acc_q      <= '0;
      cnt_q      <= '0;
      out_data_q <= '0;
      out_vld_q  <= 1'b0;
      frames_q   <= '0;
    end else begin
      acc_q      <= acc_d;
      cnt_q      <= cnt_d;
      out_data_q <= out_data_d;
      out_vld_q  <= out_vld_d;
      frames_q   <= frames_d;
    end
  end

endmodule

// File: tb/tb_dot_product_reduce.sv
// Bench for dot_product_reduce: three instances (NUM_TERMS 4, 2, 1) driven from shared arrays.
module tb_dot_product_reduce;

  logic ap_clk = 1'b0;
  logic rst_n  = 1'b0;
  always #5 ap_clk = ~ap_clk;

  logic [31:0] a [3];
  logic [31:0] b [3];
  logic [2:0]  va, vb, oack;
  logic [2:0]  acka, ackb, ov;
  logic [31:0] od [3];
  logic [15:0] fd [3];

  for (genvar k = 0; k < 3; k++) begin : g
    localparam int N = (k == 0) ? 4 : ((k == 1) ? 2 : 1);
    dot_product_reduce_if ifc ();
    assign ifc.Input_1_V_V         = a[k];
    assign ifc.Input_1_V_V_ap_vld  = va[k];
    assign ifc.Input_2_V_V         = b[k];
    assign ifc.Input_2_V_V_ap_vld  = vb[k];
    assign ifc.Output_1_V_V_ap_ack = oack[k];
    assign acka[k] = ifc.Input_1_V_V_ap_ack;
    assign ackb[k] = ifc.Input_2_V_V_ap_ack;
    assign od[k]   = ifc.Output_1_V_V;
    assign ov[k]   = ifc.Output_1_V_V_ap_vld;
    dot_product_reduce #(.NUM_TERMS(N), .CNT_BITS(8)) u_dut (
      .ap_clk(ap_clk), .ap_rst_n(rst_n), .s(ifc), .frames_done(fd[k])
    );
  end

  int n_checks = 0;
  int n_errs   = 0;
  int exp_fd [3];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errs++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Drive one pair for one cycle; it must be accepted in that cycle.
  task automatic send(input int k, input logic [31:0] x, input logic [31:0] y);
    a[k] = x; b[k] = y; va[k] = 1'b1; vb[k] = 1'b1;
    @(negedge ap_clk);
    chk("send_ack1", 32'(acka[k]), 32'd1);
    chk("send_ack2", 32'(ackb[k]), 32'd1);
    @(posedge ap_clk); #1;
    va[k] = 1'b0; vb[k] = 1'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #12;
    rst_n = 1'b1;
    for (int k = 0; k < 3; k++) exp_fd[k] = 0;
    @(posedge ap_clk); #1;
  endtask

  typedef struct {
    logic [31:0] xa [4];
    logic [31:0] xb [4];
    logic [31:0] total;
  } frame_t;

  frame_t tbl [3];

  initial begin
    tbl[0] = '{xa: '{1, 3, 5, 7}, xb: '{2, 4, 6, 8}, total: 32'd36};
    tbl[1] = '{xa: '{32'h7FFFFFFF, 32'hFFFFFFFF, 1, 2},
               xb: '{1, 0, 1, 3}, total: 32'h80000006};
    tbl[2] = '{xa: '{-32'sd5, 10, 0, 100}, xb: '{-32'sd6, 1, 0, 200}, total: 32'd300};

    for (int k = 0; k < 3; k++) begin
      a[k] = '0; b[k] = '0; exp_fd[k] = 0;
    end
    va = '0; vb = '0; oack = '1;
    do_reset();

    @(negedge ap_clk);
    for (int k = 0; k < 3; k++) begin
      chk("rst_vld", 32'(ov[k]), 32'd0);
      chk("rst_data", od[k], 32'd0);
      chk("rst_fd", 32'(fd[k]), 32'd0);
      chk("rst_ack", 32'(acka[k] | ackb[k]), 32'd0);
    end
    @(posedge ap_clk); #1;

    // Table frames, NUM_TERMS=4, consecutive pairs, output always acked.
    for (int f = 0; f < 3; f++) begin
      for (int t = 0; t < 4; t++) begin
        if (t == 3) chk("tbl_novld_early", 32'(ov[0]), 32'd0);
        send(0, tbl[f].xa[t], tbl[f].xb[t]);
      end
      @(negedge ap_clk);
      chk("tbl_vld", 32'(ov[0]), 32'd1);
      chk("tbl_total", od[0], tbl[f].total);
      @(posedge ap_clk); #1;
      exp_fd[0]++;
      @(negedge ap_clk);
      chk("tbl_vld_one_cycle", 32'(ov[0]), 32'd0);
      chk("tbl_fd", 32'(fd[0]), 32'(exp_fd[0]));
      @(posedge ap_clk); #1;
    end

    // Modular wrap, NUM_TERMS=2.
    send(1, 32'h7FFFFFFF, 32'd1);
    send(1, 32'hFFFFFFFF, 32'd0);
    @(negedge ap_clk);
    chk("wrap_total", od[1], 32'h7FFFFFFF);
    chk("wrap_vld", 32'(ov[1]), 32'd1);
    @(posedge ap_clk); #1;
    exp_fd[1]++;

    // Lone valid on input 1 is held, never acked.
    a[0] = 32'd5; va[0] = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge ap_clk);
      chk("lone_ack1", 32'(acka[0]), 32'd0);
      chk("lone_ack2", 32'(ackb[0]), 32'd0);
      @(posedge ap_clk); #1;
    end
    b[0] = 32'd6; vb[0] = 1'b1;
    @(negedge ap_clk);
    chk("pair_ack1", 32'(acka[0]), 32'd1);
    chk("pair_ack2", 32'(ackb[0]), 32'd1);
    @(posedge ap_clk); #1;
    va[0] = 1'b0; vb[0] = 1'b0;
    for (int i = 0; i < 3; i++) send(0, 32'd1, 32'd1);
    @(negedge ap_clk);
    chk("pair_total", od[0], 32'd17);
    @(posedge ap_clk); #1;
    exp_fd[0]++;

    // Backpressure, NUM_TERMS=2.
    oack[1] = 1'b0;
    send(1, 32'd1, 32'd1);
    send(1, 32'd1, 32'd1);
    send(1, 32'd1, 32'd1);
    a[1] = 32'd1; b[1] = 32'd1; va[1] = 1'b1; vb[1] = 1'b1;
    for (int i = 0; i < 2; i++) begin
      @(negedge ap_clk);
      chk("bp_stall_ack", 32'(acka[1] | ackb[1]), 32'd0);
      chk("bp_hold_vld", 32'(ov[1]), 32'd1);
      chk("bp_hold_data", od[1], 32'd4);
      @(posedge ap_clk); #1;
    end
    oack[1] = 1'b1;
    @(negedge ap_clk);
    chk("bp_release_ack", 32'(acka[1] & ackb[1]), 32'd1);
    @(posedge ap_clk); #1;
    oack[1] = 1'b0; va[1] = 1'b0; vb[1] = 1'b0;
    exp_fd[1]++;
    @(negedge ap_clk);
    chk("bp_second_vld", 32'(ov[1]), 32'd1);
    chk("bp_second_data", od[1], 32'd4);
    chk("bp_fd_a", 32'(fd[1]), 32'(exp_fd[1]));
    @(posedge ap_clk); #1;
    oack[1] = 1'b1;
    @(posedge ap_clk); #1;
    exp_fd[1]++;
    @(negedge ap_clk);
    chk("bp_fd_b", 32'(fd[1]), 32'(exp_fd[1]));
    chk("bp_drained", 32'(ov[1]), 32'd0);
    @(posedge ap_clk); #1;

    // Asynchronous reset mid-frame, NUM_TERMS=4.
    send(0, 32'd7, 32'd7);
    send(0, 32'd7, 32'd7);
    #2 rst_n = 1'b0;
    #1;
    chk("amid_vld", 32'(ov[0]), 32'd0);
    chk("amid_fd", 32'(fd[0]), 32'd0);
    #3 rst_n = 1'b1;
    for (int k = 0; k < 3; k++) exp_fd[k] = 0;
    @(posedge ap_clk); #1;
    for (int i = 0; i < 4; i++) send(0, 32'd1, 32'd1);
    @(negedge ap_clk);
    chk("post_rst_total", od[0], 32'd8);
    @(posedge ap_clk); #1;

    // NUM_TERMS=1: back-to-back totals.
    a[2] = 32'd10; b[2] = 32'd20; va[2] = 1'b1; vb[2] = 1'b1;
    @(posedge ap_clk); #1;
    a[2] = 32'd30; b[2] = 32'd40;
    @(negedge ap_clk);
    chk("n1_first_vld", 32'(ov[2]), 32'd1);
    chk("n1_first", od[2], 32'd30);
    @(posedge ap_clk); #1;
    va[2] = 1'b0; vb[2] = 1'b0;
    @(negedge ap_clk);
    chk("n1_second_vld", 32'(ov[2]), 32'd1);
    chk("n1_second", od[2], 32'd70);
    @(posedge ap_clk); #1;
    @(negedge ap_clk);
    chk("n1_idle", 32'(ov[2]), 32'd0);
    chk("n1_fd", 32'(fd[2]), 32'd2);
    @(posedge ap_clk); #1;

    // Random traffic on NUM_TERMS=4 against a frame-level model.
    do_reset();
    begin
      int          nterms = 0;
      logic [31:0] partial = '0;
      bit          pend = 1'b0;
      logic [31:0] pend_val = '0;
      int          m_fd = 0;
      bit          exp_ack;
      for (int c = 0; c < 400; c++) begin
        a[0] = $urandom; b[0] = $urandom;
        va[0] = ($urandom_range(0, 3) != 0);
        vb[0] = ($urandom_range(0, 3) != 0);
        oack[0] = ($urandom_range(0, 2) != 0);
        @(negedge ap_clk);
        exp_ack = va[0] && vb[0] && (nterms != 3 || !pend || oack[0]);
        chk("rnd_ack1", 32'(acka[0]), 32'(exp_ack));
        chk("rnd_ack2", 32'(ackb[0]), 32'(exp_ack));
        chk("rnd_vld", 32'(ov[0]), 32'(pend));
        if (pend) chk("rnd_data", od[0], pend_val);
        chk("rnd_fd", 32'(fd[0]), 32'(m_fd & 16'hFFFF));
        if (pend && oack[0]) begin
          pend = 1'b0;
          m_fd++;
        end
        if (exp_ack) begin
          partial = partial + a[0] + b[0];
          nterms++;
          if (nterms == 4) begin
            pend = 1'b1;
            pend_val = partial;
            partial = '0;
            nterms = 0;
          end
        end
        @(posedge ap_clk); #1;
      end
    end

    $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
    $finish;
  end

endmodule

// File: doc/dot_product_reduce.md
Name: dot_product_reduce

Overview:
- User-side operator placed directly downstream of the dotProduct_7 operator inside a leaf.
- Consumes its two 32-bit output streams as paired partial sums. Adds each pair and accumulates NUM_TERMS pairs per frame.
- Emits one 32-bit total per frame on a single ap_vld/ap_ack output stream, which feeds leaf_interface port 1.
- A separate result register lets accumulation of the next frame overlap with output backpressure.

Parameters:
- NUM_TERMS, 8, number of input pairs per frame (≥1).
- CNT_BITS, 8, width of the term counter; must hold NUM_TERMS-1.

Ports:
- ap_clk  input  1  sole clock (user clock domain).
- ap_rst_n  input  1  asynchronous, active-low reset.
- Input_1_V_V  input  32  partial sum A.
- Input_1_V_V_ap_vld  input  1  A valid.
- Input_1_V_V_ap_ack  output  1  A consumed this cycle.
- Input_2_V_V  input  32  partial sum B.
- Input_2_V_V_ap_vld  input  1  B valid.
- Input_2_V_V_ap_ack  output  1  B consumed this cycle.
- Output_1_V_V  output  32  frame total.
- Output_1_V_V_ap_vld  output  1  total valid.
- Output_1_V_V_ap_ack  input  1  downstream accepted total.
- frames_done  output  16  count of totals accepted downstream; wraps at 0xFFFF→0.

Behaviour:
- Transfer rule: a word transfers on a rising ap_clk edge where vld=1 and ack=1 in the same cycle.
- Reset: ap_rst_n=0 asynchronously clears acc, cnt, out_data, out_vld and frames_done to 0. Both input acks are combinational and read 0 while out of reset with no pair present.
- Reset mid-frame: the partial accumulation is discarded. A pending total is dropped without being counted.
- Pair rule: inputs are consumed only as a pair.
  - Define pair_ok = Input_1_V_V_ap_vld & Input_2_V_V_ap_vld.
  - Both acks equal pair_ok & (cnt != NUM_TERMS-1 | slot_free), with slot_free = !out_vld | Output_1_V_V_ap_ack. This is a combinational path from the output ack.
  - A lone vld on one input never asserts either ack. The waiting word is held and not consumed.
- Accept, non-last term (cnt < NUM_TERMS-1): acc <= acc + A + B; cnt <= cnt+1.
- Accept, last term (cnt == NUM_TERMS-1):
  - out_data <= acc + A + B; out_vld <= 1.
  - acc <= 0; cnt <= 0.
  - NUM_TERMS=1 gives a total for every pair.
- Arithmetic: 32-bit two's-complement, modulo 2^32. No saturation and no overflow flag.
- Output: Output_1_V_V = out_data and Output_1_V_V_ap_vld = out_vld, both registered.
  - On out_vld & Output_1_V_V_ap_ack: frames_done increments, and out_vld clears unless a new last-term accept occurs in the same cycle. In that case out_vld stays 1 and out_data takes the new total, giving back-to-back totals with no bubble.
  - out_data holds stable while out_vld=1 and ack=0.
- Latency: the total is valid on the cycle after the last pair is accepted.
- Throughput: one pair per cycle, with no bubble between frames.
- Overlap: while a total is pending, non-last terms of the next frame are still accepted. The last term stalls (acks low) until slot_free.
- No ap_start/ap_done. The block is free-running.

Test Plan:
- NUM_TERMS=4, pairs (1,2),(3,4),(5,6),(7,8) on consecutive cycles, Output ack held 1 -> Output_1_V_V=36 valid exactly 1 cycle after the 4th accept; frames_done=1.
- Wrap: NUM_TERMS=2, pairs (0x7FFFFFFF,1),(0xFFFFFFFF,0) -> total 0x7FFFFFFF.
- Pairing: Input_1 vld=1 for 5 cycles with Input_2 vld=0 -> both acks stay 0 and the word is held. Input_2 then asserts -> both acks 1 in the same cycle.
- Backpressure: NUM_TERMS=2, output ack=0, feed 4 pairs of (1,1) -> first total 4 held stable. Pair 3 accepted; pair 4 stalls with acks 0. Raise output ack for 1 cycle -> pair 4 accepted in that cycle and the second total 4 appears next cycle with no bubble; frames_done=1, then 2 once it is acked.
- Reset mid-frame: NUM_TERMS=4, accept 2 pairs, then pulse ap_rst_n low asynchronously -> out_vld=0, frames_done=0. A fresh frame of (1,1)×4 yields 8, not the stale sum.
- NUM_TERMS=1, pairs (10,20),(30,40) back-to-back with ack=1 -> totals 30, 70 on consecutive cycles.
